// File: rtl/rr_arb_5_pkg.sv
// Shared constants, state encoding and grant helper for the 5-channel
// round-robin arbiter that drives the 5:1 mux select lines.
package mux5_pkg;

  localparam int unsigned N_CH  = 5;
  localparam int unsigned SEL_W = 3;
  localparam logic [SEL_W-1:0] SEL_IDLE = 3'd5;

  typedef enum logic {
    IDLE,
    GRANT
  } arb_state_t;

  function automatic logic [N_CH-1:0] onehot_ch(input logic [SEL_W-1:0] idx);
    logic [N_CH-1:0] r;
    r = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (idx == SEL_W'(k)) r[k] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arb_5_if.sv
// Requester/arbiter bundle: request side drives en/req/done, arbiter
// returns the mux select, one-hot grant and status flags.
interface rr_arb_5_if;
  import mux5_pkg::*;

  logic                 en;
  logic [N_CH-1:0]      req;
  logic                 done;
  logic [SEL_W-1:0]     sel;
  logic [N_CH-1:0]      gnt;
  logic                 busy;
  logic                 timeout;

  modport master (
    output en, req, done,
    input  sel, gnt, busy, timeout
  );

  modport slave (
    input  en, req, done,
    output sel, gnt, busy, timeout
  );

endinterface

// File: rtl/rr_arb_5_pick.sv
// Combinational round-robin search: first requester after ptr, wrapping
// modulo 5 so the unused codes 5..7 are never produced as a winner.
module rr_pick_5
  import mux5_pkg::*;
(
  input  logic [N_CH-1:0]  req_i,
  input  logic [SEL_W-1:0] ptr_i,
  output logic             found_o,
  output logic [SEL_W-1:0] idx_o
);

  logic [SEL_W-1:0] cand;

  always_comb begin
    found_o = 1'b0;
    idx_o   = SEL_IDLE;
    cand    = '0;
    for (int unsigned i = 1; i <= N_CH; i++) begin
      cand = SEL_W'((32'(ptr_i) + i) % N_CH);
      if (!found_o && req_i[cand]) begin
        found_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/rr_arb_5.sv
// Round-robin arbiter owning the 5:1 mux select; holds a grant until done,
// request drop or hold timeout, parking sel on code 5 while idle.
module rr_arb_5
  import mux5_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  rr_arb_5_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(MAX_HOLD) + 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  arb_state_t       state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [N_CH-1:0]  gnt_q, gnt_d;
  logic             timeout_q, timeout_d;

  logic             pick_found;
  logic [SEL_W-1:0] pick_idx;
  logic             rel_user;
  logic             rel_to;

  rr_pick_5 u_pick (
    .req_i   (bus.req),
    .ptr_i   (ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  // Requester-driven release (done or own request dropped) outranks timeout.
  assign rel_user = bus.done || ~|(bus.req & gnt_q);
  assign rel_to   = (hold_q == HOLD_LAST);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    sel_d     = sel_q;
    gnt_d     = gnt_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.en && pick_found) begin
          state_d = GRANT;
          sel_d   = pick_idx;
          gnt_d   = onehot_ch(pick_idx);
          ptr_d   = pick_idx;
          hold_d  = '0;
        end
      end
      GRANT: begin
        if (rel_user || rel_to) begin
          state_d   = IDLE;
          sel_d     = SEL_IDLE;
          gnt_d     = '0;
          timeout_d = !rel_user;
        end else begin
          hold_d = hold_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        sel_d   = SEL_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= 3'd4;
      hold_q    <= '0;
      sel_q     <= SEL_IDLE;
      gnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      sel_q     <= sel_d;
      gnt_q     <= gnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.sel     = sel_q;
  assign bus.gnt     = gnt_q;
  assign bus.busy    = |gnt_q;
  assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_rr_arb_5.sv
// Directed table-driven bench for rr_arb_5 with MAX_HOLD = 4.
module tb_rr_arb_5;
  import mux5_pkg::*;

  logic clk;
  logic rst;

  rr_arb_5_if bus ();

  rr_arb_5 #(.MAX_HOLD(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string      name;
    logic       en;
    logic [4:0] req;
    logic       done;
    logic [2:0] exp_sel;
    logic [4:0] exp_gnt;
    logic       exp_to;
  } vec_t;

  vec_t vecs[$];
  int   n_chk;
  int   n_fail;

  function automatic vec_t mk(string name, logic en, logic [4:0] req, logic done,
                              logic [2:0] s, logic [4:0] g, logic t);
    vec_t v;
    v.name = name; v.en = en; v.req = req; v.done = done;
    v.exp_sel = s; v.exp_gnt = g; v.exp_to = t;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string name, input logic [2:0] s, input logic [4:0] g,
                          input logic t);
    chk({name, ".sel"},     8'(bus.sel),     8'(s));
    chk({name, ".gnt"},     8'(bus.gnt),     8'(g));
    chk({name, ".busy"},    8'(bus.busy),    8'(|g));
    chk({name, ".timeout"}, 8'(bus.timeout), 8'(t));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst      = 1'b1;
    bus.en   = 1'b1;
    bus.req  = 5'b11111;
    bus.done = 1'b0;

    // Full rotation from reset, done pulsed the cycle after each grant
    vecs.push_back(mk("rot_g0",  1, 5'b11111, 0, 3'd0, 5'b00001, 0));
    vecs.push_back(mk("rot_i0",  1, 5'b11111, 1, 3'd5, 5'b00000, 0));
    vecs.push_back(mk("rot_g1",  1, 5'b11111, 0, 3'd1, 5'b00010, 0));
    vecs.push_back(mk("rot_i1",  1, 5'b11111, 1, 3'd5, 5'b00000, 0));
    vecs.push_back(mk("rot_g2",  1, 5'b11111, 0, 3'd2, 5'b00100, 0));
    vecs.push_back(mk("rot_i2",  1, 5'b11111, 1, 3'd5, 5'b00000, 0));
    vecs.push_back(mk("rot_g3",  1, 5'b11111, 0, 3'd3, 5'b01000, 0));
    vecs.push_back(mk("rot_i3",  1, 5'b11111, 1, 3'd5, 5'b00000, 0));
    vecs.push_back(mk("rot_g4",  1, 5'b11111, 0, 3'd4, 5'b10000, 0));
    vecs.push_back(mk("rot_i4",  1, 5'b11111, 1, 3'd5, 5'b00000, 0));
    vecs.push_back(mk("rot_g0b", 1, 5'b11111, 0, 3'd0, 5'b00001, 0));
    vecs.push_back(mk("rot_i0b", 1, 5'b11111, 1, 3'd5, 5'b00000, 0));
    // Wrap skip: grant 3, then 01001 skips idle channel 4 and lands on 0
    vecs.push_back(mk("wrap_g3", 1, 5'b01000, 0, 3'd3, 5'b01000, 0));
    vecs.push_back(mk("wrap_i3", 1, 5'b01000, 1, 3'd5, 5'b00000, 0));
    vecs.push_back(mk("wrap_g0", 1, 5'b01001, 0, 3'd0, 5'b00001, 0));
    vecs.push_back(mk("wrap_i0", 1, 5'b01001, 1, 3'd5, 5'b00000, 0));
    // Own request drops on cycle 2; other bits toggle meanwhile
    vecs.push_back(mk("drop_g2", 1, 5'b00100, 0, 3'd2, 5'b00100, 0));
    vecs.push_back(mk("drop_oth",1, 5'b10101, 0, 3'd2, 5'b00100, 0));
    vecs.push_back(mk("drop_rel",1, 5'b10001, 0, 3'd5, 5'b00000, 0));
    // Enable gating
    vecs.push_back(mk("en_off0", 0, 5'b10000, 0, 3'd5, 5'b00000, 0));
    vecs.push_back(mk("en_off1", 0, 5'b10000, 0, 3'd5, 5'b00000, 0));
    vecs.push_back(mk("en_on",   1, 5'b10000, 0, 3'd4, 5'b10000, 0));
    vecs.push_back(mk("en_mid",  0, 5'b10000, 0, 3'd4, 5'b10000, 0));
    vecs.push_back(mk("en_done", 0, 5'b10000, 1, 3'd5, 5'b00000, 0));
    vecs.push_back(mk("en_off2", 0, 5'b10000, 0, 3'd5, 5'b00000, 0));
    // Timeout: four grant cycles, one-cycle pulse, regrant after one idle cycle
    vecs.push_back(mk("to_g",    1, 5'b00100, 0, 3'd2, 5'b00100, 0));
    vecs.push_back(mk("to_h1",   1, 5'b00100, 0, 3'd2, 5'b00100, 0));
    vecs.push_back(mk("to_h2",   1, 5'b00100, 0, 3'd2, 5'b00100, 0));
    vecs.push_back(mk("to_h3",   1, 5'b00100, 0, 3'd2, 5'b00100, 0));
    vecs.push_back(mk("to_rel",  1, 5'b00100, 0, 3'd5, 5'b00000, 1));
    vecs.push_back(mk("to_regr", 1, 5'b00100, 0, 3'd2, 5'b00100, 0));
    // done coincides with the hold limit: no timeout pulse
    vecs.push_back(mk("sim_h1",  1, 5'b00100, 0, 3'd2, 5'b00100, 0));
    vecs.push_back(mk("sim_h2",  1, 5'b00100, 0, 3'd2, 5'b00100, 0));
    vecs.push_back(mk("sim_h3",  1, 5'b00100, 0, 3'd2, 5'b00100, 0));
    vecs.push_back(mk("sim_rel", 1, 5'b00100, 1, 3'd5, 5'b00000, 0));

    @(posedge clk);
    @(posedge clk);
    #1;
    chk_outs("reset", 3'd5, 5'b00000, 1'b0);
    #4;
    rst = 1'b0;
    #2;

    foreach (vecs[i]) begin
      bus.en   = vecs[i].en;
      bus.req  = vecs[i].req;
      bus.done = vecs[i].done;
      step();
      chk_outs(vecs[i].name, vecs[i].exp_sel, vecs[i].exp_gnt, vecs[i].exp_to);
    end

    // Asynchronous reset in the middle of a grant
    bus.en = 1'b1; bus.req = 5'b11111; bus.done = 1'b0;
    step();
    chk_outs("pre_rst_g3", 3'd3, 5'b01000, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk_outs("async_rst", 3'd5, 5'b00000, 1'b0);
    step();
    chk_outs("rst_hold", 3'd5, 5'b00000, 1'b0);
    #3;
    rst = 1'b0;
    step();
    chk_outs("post_rst_g0", 3'd0, 5'b00001, 1'b0);
    bus.done = 1'b1;
    step();
    chk_outs("post_rst_rel", 3'd5, 5'b00000, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_arb_5.md
# rr_arb_5

Round-robin arbiter that owns the select lines of the 5-input, 3-bit-select multiplexer. Five requesters compete for one shared 5:1 data path. The arbiter grants one requester at a time, drives `sel` straight into the mux `S` input, and holds the grant until the requester finishes, drops its request, or hits a hold timeout. While idle, `sel` parks on an unused code, so the mux output reads 0.

## Interface
- `MAX_HOLD`, 16: maximum cycles a grant may be held. Legal range ≥ 1. Hold counter width is `$clog2(MAX_HOLD)+1`.
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `en` input 1: when low, no new grant is issued; a grant already in progress continues.
- `req` input 5: request per channel; bit k corresponds to mux input `I[k]`.
- `done` input 1: single-cycle release from the current grantee; ignored while idle.
- `sel` output 3: mux select. Values 0–4 mean the granted channel; 5 is the idle park code.
- `gnt` output 5: one-hot grant, or all-zero.
- `busy` output 1: a grant is active; equals `|gnt`.
- `timeout` output 1: one-cycle pulse marking a forced release.

## Operation
- FSM states are `IDLE` and `GRANT`.
- **IDLE → GRANT** at a clock edge when `en && |(req)`.
  - The winner is the first requesting channel searching `ptr+1, ptr+2, … ptr+5`, modulo 5 (not modulo 8).
  - At that edge: `sel` ← winner, `gnt` ← one-hot(winner), `ptr` ← winner, `hold_cnt` ← 0.
- **GRANT, release** occurs at a clock edge when any of these is true in that cycle:
  - (a) `done` = 1,
  - (b) `req[sel]` = 0,
  - (c) `hold_cnt == MAX_HOLD-1`.
- **On release:** go to `IDLE`, `sel` ← 5, `gnt` ← 0.
  - `timeout` ← 1 only if (c) holds and neither (a) nor (b) holds. Otherwise `timeout` ← 0.
- **GRANT, no release:** `hold_cnt` increments. `sel` and `gnt` are stable.
- **Priority of simultaneous release causes:** `done`/drop wins over timeout, so no `timeout` pulse.
- **`timeout` timing:** it is 0 in every cycle except the single cycle after a forced release.
- **Other `req` bits** change freely during `GRANT` with no effect.
- **Park code:** `sel` = 5 drives the mux padding path, so the mux output is 0 while idle. Codes 6 and 7 are never driven.

## Timing
- **Reset values (immediate on `rst` high, no clock needed):** `sel` = 5, `gnt` = 0, `busy` = 0, `timeout` = 0, state `IDLE`, `ptr` = 4 (channel 0 has first priority), `hold_cnt` = 0.
- **Grant latency:** `req` sampled in `IDLE` at edge N gives `gnt`/`sel` valid after edge N.
- **Grant length:** `gnt` stays high for at most `MAX_HOLD` cycles.
- **Release:** the cause sampled at edge M gives `gnt` = 0 after edge M.
- **Idle gap:** there is always at least one `IDLE` cycle between consecutive grants. The earliest next grant appears after edge M+1.
- **Reset mid-grant:** outputs return to reset values asynchronously. No `timeout` pulse. Round-robin history is lost.
- **Register map:** all outputs are registered, with no combinational path from inputs to outputs. `busy` is derived from registered `gnt`.

## Structure
- **Package `mux5_pkg`:**
  - `N_CH` = 5, `SEL_W` = 3, `SEL_IDLE` = 3'd5,
  - `typedef enum logic {IDLE, GRANT} arb_state_t`.
- **Sub-module `rr_pick_5`:** combinational. Inputs `req[4:0]` and `ptr[2:0]`. Outputs `found` and `idx[2:0]`, where `idx` is the next requester after `ptr`, modulo 5.
- **Top level:** FSM, `ptr`, `hold_cnt`, and output registers.
- **Integration:** `rr_arb_5.sel` connects directly to the 5:1 mux `S`. The requesters' data bus connects to mux `I`.

## Test plan
- **Reset:** assert `rst` mid-cycle with `req` = 5'b11111 → immediately `sel` = 5, `gnt` = 0, `busy` = 0, `timeout` = 0. After release, the first grant goes to channel 0.
- **Full rotation:** `req` = 5'b11111, `done` pulsed the cycle after each grant → grants 0, 1, 2, 3, 4, 0. `sel` matches. One idle cycle (`sel` = 5) between each.
- **Wrap skip:** after granting channel 3 and releasing, `req` = 5'b01001 → next grant is channel 0 (`gnt` = 5'b00001, `sel` = 0). Channel 4 is not requesting and is skipped.
- **Timeout:** `MAX_HOLD` = 4, `req` = 5'b00100 held, `done` = 0 → `gnt` = 5'b00100 for exactly 4 cycles. `timeout` = 1 for one cycle as `gnt` drops. Channel 2 is then re-granted after one idle cycle.
- **Simultaneous release causes:** `MAX_HOLD` = 4, `done` = 1 on the 4th grant cycle → release with `timeout` = 0. Separately, `req[sel]` drops on cycle 2 → release, `timeout` = 0.
- **Enable gating:** `en` = 0 with `req` = 5'b10000 → no grant, `sel` = 5. `en` rises → `gnt` = 5'b10000 one cycle later. `en` dropped mid-grant → grant continues until `done`.
